pipe_ctrl: RTL

- Pipeline sequencer that drives the load/clear pins of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC load. It is the producer side of the load/clear interface those registers consume.
- Resolves split I/D cache stalls, load-use hazards and EX-stage redirects.
- Buffers a single-cycle cache response that arrives while the other cache is still busy, so the response is not lost.
- Sits between the datapath stages and the two cache ports.

---
 rtl/pipe_ctrl_pkg.sv | 38 +++
 rtl/pipe_ctrl_if.sv | 64 ++++++
 rtl/pipe_ctrl_resp_hold.sv | 46 ++++
 rtl/pipe_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM state, control bundle for the
// stage registers, and the datapath widths.
package pipe_ctrl_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        I_WAIT  = 2'd1,
        D_WAIT  = 2'd2,
        ID_WAIT = 2'd3
    } pipe_ctrl_state_t;

    // Load/clear pins for every pipeline register, in pipeline order.
    typedef struct packed {
        logic pc_load;
        logic if_id_load;
        logic if_id_clear;
        logic id_ex_load;
        logic id_ex_clear;
        logic ex_mem_load;
        logic ex_mem_clear;
        logic mem_wb_load;
    } pipe_ctrl_t;

    function automatic pipe_ctrl_state_t wait_state(input logic busy_i, input logic busy_d);
        pipe_ctrl_state_t s;
        case ({busy_i, busy_d})
            2'b10:   s = I_WAIT;
            2'b01:   s = D_WAIT;
            2'b11:   s = ID_WAIT;
            default: s = RUN;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Datapath/cache-facing signal bundle of the pipeline sequencer.
// master = sequencer side, slave = datapath and caches.
interface pipe_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    import pipe_ctrl_pkg::*;

    logic                if_req;
    logic                imem_resp;
    logic [XLEN-1:0]     imem_rdata;
    logic                imem_read;
    logic [XLEN-1:0]     if_instr;

    logic                mem_rd_req;
    logic                mem_wr_req;
    logic                dmem_resp;
    logic [XLEN-1:0]     dmem_rdata;
    logic                dmem_read;
    logic                dmem_write;
    logic [XLEN-1:0]     mem_rdata;

    logic [REG_W-1:0]    id_rs1;
    logic [REG_W-1:0]    id_rs2;
    logic                id_use_rs1;
    logic                id_use_rs2;
    logic [REG_W-1:0]    ex_rd;
    logic                ex_is_load;
    logic                ex_redirect;

    logic                pc_load;
    logic                if_id_load;
    logic                if_id_clear;
    logic                id_ex_load;
    logic                id_ex_clear;
    logic                ex_mem_load;
    logic                ex_mem_clear;
    logic                mem_wb_load;

    logic [CNT_W-1:0]    stall_cycles;
    logic [CNT_W-1:0]    flush_count;
    logic                hang_err;
    pipe_ctrl_state_t    dbg_state;

    modport master (
        input  if_req, imem_resp, imem_rdata,
        input  mem_rd_req, mem_wr_req, dmem_resp, dmem_rdata,
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load, ex_redirect,
        output imem_read, if_instr, dmem_read, dmem_write, mem_rdata,
        output pc_load, if_id_load, if_id_clear, id_ex_load, id_ex_clear,
        output ex_mem_load, ex_mem_clear, mem_wb_load,
        output stall_cycles, flush_count, hang_err, dbg_state
    );

    modport slave (
        output if_req, imem_resp, imem_rdata,
        output mem_rd_req, mem_wr_req, dmem_resp, dmem_rdata,
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load, ex_redirect,
        input  imem_read, if_instr, dmem_read, dmem_write, mem_rdata,
        input  pc_load, if_id_load, if_id_clear, id_ex_load, id_ex_clear,
        input  ex_mem_load, ex_mem_clear, mem_wb_load,
        input  stall_cycles, flush_count, hang_err, dbg_state
    );

endinterface

// File: rtl/pipe_ctrl_resp_hold.sv
// Holds a cache response that arrived while the other cache was still busy,
// and presents it until the pipeline advances.
module pipe_ctrl_resp_hold
    import pipe_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            resp,
    input  logic [XLEN-1:0] rdata,
    input  logic            other_busy,
    input  logic            advance,
    output logic            done,
    output logic [XLEN-1:0] data_c
);

    logic            done_q, done_d;
    logic [XLEN-1:0] hold_q, hold_d;
    logic            capture;

    // Capture only when the other port is stalling us; advance releases the hold.
    always_comb begin
        capture = resp & other_busy & ~done_q;
        done_d  = done_q;
        hold_d  = hold_q;
        if (advance) begin
            done_d = 1'b0;
        end else if (capture) begin
            done_d = 1'b1;
            hold_d = rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
            hold_q <= '0;
        end else begin
            done_q <= done_d;
            hold_q <= hold_d;
        end
    end

    assign done   = done_q;
    assign data_c = done_q ? hold_q : rdata;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: resolves split I/D cache stalls, load-use hazards and
// EX redirects into load/clear controls for the pipeline registers.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 32
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.master p
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    pipe_ctrl_state_t state_q, state_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             hang_err_q, hang_err_d;

    logic       i_done, d_done;
    logic       busy_i, busy_d, stall, advance, hz;
    pipe_ctrl_t ctl;

    assign busy_i  = p.if_req & ~p.imem_resp & ~i_done;
    assign busy_d  = (p.mem_rd_req | p.mem_wr_req) & ~p.dmem_resp & ~d_done;
    assign stall   = busy_i | busy_d;
    assign advance = ~stall;

    assign hz = p.ex_is_load && (p.ex_rd != '0) &&
                ((p.id_use_rs1 && (p.id_rs1 == p.ex_rd)) ||
                 (p.id_use_rs2 && (p.id_rs2 == p.ex_rd)));

    pipe_ctrl_resp_hold u_i_hold (
        .clk        (clk),
        .rst        (rst),
        .resp       (p.imem_resp),
        .rdata      (p.imem_rdata),
        .other_busy (busy_d),
        .advance    (advance),
        .done       (i_done),
        .data_c     (p.if_instr)
    );

    pipe_ctrl_resp_hold u_d_hold (
        .clk        (clk),
        .rst        (rst),
        .resp       (p.dmem_resp),
        .rdata      (p.dmem_rdata),
        .other_busy (busy_i),
        .advance    (advance),
        .done       (d_done),
        .data_c     (p.mem_rdata)
    );

    assign p.imem_read  = p.if_req & ~i_done;
    assign p.dmem_read  = p.mem_rd_req & ~d_done;
    assign p.dmem_write = p.mem_wr_req & ~d_done;

    // Next state, counters and Mealy controls; a redirect seen during a stall
    // stays in EX and is acted on at the advance cycle.
    always_comb begin
        ctl            = '0;
        state_d        = wait_state(busy_i, busy_d);
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        tmo_d          = tmo_q;
        hang_err_d     = hang_err_q;

        if (stall) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
            if (tmo_q != TMO_W'(TIMEOUT)) tmo_d = tmo_q + TMO_W'(1);
            if (tmo_q >= TMO_W'(TIMEOUT - 1)) hang_err_d = 1'b1;
        end else begin
            tmo_d = '0;
        end

        if (!rst && advance) begin
            if (p.ex_redirect) begin
                ctl.pc_load     = 1'b1;
                ctl.if_id_load  = 1'b1;
                ctl.if_id_clear = 1'b1;
                ctl.id_ex_load  = 1'b1;
                ctl.id_ex_clear = 1'b1;
                ctl.ex_mem_load = 1'b1;
                ctl.mem_wb_load = 1'b1;
                flush_count_d   = flush_count_q + CNT_W'(1);
            end else if (hz) begin
                ctl.id_ex_load  = 1'b1;
                ctl.id_ex_clear = 1'b1;
                ctl.ex_mem_load = 1'b1;
                ctl.mem_wb_load = 1'b1;
            end else begin
                ctl.pc_load     = 1'b1;
                ctl.if_id_load  = 1'b1;
                ctl.id_ex_load  = 1'b1;
                ctl.ex_mem_load = 1'b1;
                ctl.mem_wb_load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
            tmo_q          <= '0;
            hang_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
            tmo_q          <= tmo_d;
            hang_err_q     <= hang_err_d;
        end
    end

    assign p.pc_load      = ctl.pc_load;
    assign p.if_id_load   = ctl.if_id_load;
    assign p.if_id_clear  = ctl.if_id_clear;
    assign p.id_ex_load   = ctl.id_ex_load;
    assign p.id_ex_clear  = ctl.id_ex_clear;
    assign p.ex_mem_load  = ctl.ex_mem_load;
    assign p.ex_mem_clear = ctl.ex_mem_clear;
    assign p.mem_wb_load  = ctl.mem_wb_load;

    assign p.stall_cycles = stall_cycles_q;
    assign p.flush_count  = flush_count_q;
    assign p.hang_err     = hang_err_q;
    assign p.dbg_state    = state_q;

endmodule
